minmax_tracker: RTL and testbench

MINMAX_TRACKER -- requirements
Module: minmax_tracker

---
 rtl/minmax_tracker_pkg.sv | 16 +
 rtl/minmax_tracker_slt.sv | 22 ++
 rtl/minmax_tracker.sv | 123 ++++++++++++
 tb/tb_minmax_tracker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_tracker_pkg.sv
// Shared state typedefs for the min/max tracker family of blocks.
package minmax_tracker_pkg;

   localparam int MM_STATE_W = 3;

   // One word enters in FIRST/WAIT; CMP_MIN and CMP_MAX reuse the single comparator.
   typedef enum logic [MM_STATE_W-1:0] {
      IDLE    = 3'd0,
      FIRST   = 3'd1,
      WAIT    = 3'd2,
      CMP_MIN = 3'd3,
      CMP_MAX = 3'd4,
      DONE    = 3'd5
   } mm_state_t;

endpackage

// File: rtl/minmax_tracker_slt.sv
// Structural signed less-than: ripple borrow chain plus sign-bit override.
module slt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);

   logic [N:0] borrow;

   // Borrow out of the unsigned a-b; valid as signed order when the signs agree.
   always_comb begin
      borrow[0] = 1'b0;
      for (int i = 0; i < N; i++) begin
         borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
      end
   end

   assign lt = (a[N-1] ^ b[N-1]) ? a[N-1] : borrow[N];

endmodule

// File: rtl/minmax_tracker.sv
// Sequential signed min/max over a counted word sequence using one shared comparator.
module minmax_tracker
   import minmax_tracker_pkg::*;
#(
   parameter int N     = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_min,
   output logic [N-1:0]     out_max
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   mm_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_dec;
   logic [N-1:0]     cand, cand_next;
   logic [N-1:0]     run_min, min_next;
   logic [N-1:0]     run_max, max_next;
   logic [N-1:0]     cmp_a, cmp_b;
   logic             cmp_lt;
   logic             cnt_last;

   slt #(.N(N)) u_slt (
      .a  (cmp_a),
      .b  (cmp_b),
      .lt (cmp_lt)
   );

   assign cnt_dec  = cnt - CNT_ONE;
   assign cnt_last = ~|cnt_dec;
   assign out_min  = run_min;
   assign out_max  = run_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         cand    <= '0;
         run_min <= '0;
         run_max <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         cand    <= cand_next;
         run_min <= min_next;
         run_max <= max_next;
      end
   end

   // in_ready is only high in FIRST/WAIT, so in_valid alone marks a handshake there.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cand_next  = cand;
      min_next   = run_min;
      max_next   = run_max;
      in_ready   = 1'b0;
      busy       = 1'b1;
      out_valid  = 1'b0;
      cmp_a      = cand;
      cmp_b      = run_min;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && |len) begin
               state_next = FIRST;
               cnt_next   = len;
            end
         end
         FIRST: begin
            in_ready = 1'b1;
            if (in_valid) begin
               min_next   = in_data;
               max_next   = in_data;
               cnt_next   = cnt_dec;
               state_next = cnt_last ? DONE : WAIT;
            end
         end
         WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cand_next  = in_data;
               state_next = CMP_MIN;
            end
         end
         CMP_MIN: begin
            if (cmp_lt) begin
               min_next = cand;
            end
            state_next = CMP_MAX;
         end
         CMP_MAX: begin
            cmp_a = run_max;
            cmp_b = cand;
            if (cmp_lt) begin
               max_next = cand;
            end
            cnt_next   = cnt_dec;
            state_next = cnt_last ? DONE : WAIT;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker with a transaction-level reference model.
module tb_minmax_tracker;

   localparam int N     = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic [N-1:0]     in_data = '0;
   logic             out_ready = 1'b0;
   logic             in_ready, busy, out_valid;
   logic [N-1:0]     out_min, out_max;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [N-1:0] word_q[$];

   always #5 clk = ~clk;

   minmax_tracker #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min   (out_min),
      .out_max   (out_max)
   );

   // Reference: one accepted word costs two comparison cycles before the next may enter.
   logic               m_busy = 1'b0, m_ready = 1'b0, m_valid = 1'b0, m_first = 1'b0;
   logic signed [N-1:0] m_min = '0, m_max = '0, m_pend = '0;
   int                 m_left = 0, m_gap = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_ready <= 1'b0; m_valid <= 1'b0; m_first <= 1'b0;
         m_min <= '0; m_max <= '0; m_pend <= '0; m_left <= 0; m_gap <= 0;
      end else if (!m_busy) begin
         if (start && len != 0) begin
            m_busy <= 1'b1; m_ready <= 1'b1; m_first <= 1'b1; m_left <= int'(len);
         end
      end else if (m_valid) begin
         if (out_ready) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
         end
      end else if (m_gap == 2) begin
         if (m_pend < m_min) m_min <= m_pend;
         m_gap <= 1;
      end else if (m_gap == 1) begin
         if (m_max < m_pend) m_max <= m_pend;
         m_gap  <= 0;
         m_left <= m_left - 1;
         if (m_left == 1) m_valid <= 1'b1;
         else             m_ready <= 1'b1;
      end else if (m_ready && in_valid) begin
         if (m_first) begin
            m_min <= in_data; m_max <= in_data; m_first <= 1'b0;
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_ready <= 1'b0; m_valid <= 1'b1;
            end
         end else begin
            m_pend <= in_data; m_ready <= 1'b0; m_gap <= 2;
         end
      end
   end

   task automatic compare(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic compareBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting on DUT", name);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         compareBit("busy", busy, m_busy);
         compareBit("in_ready", in_ready, m_ready);
         compareBit("out_valid", out_valid, m_valid);
         compare("out_min", out_min, m_min);
         compare("out_max", out_max, m_max);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkZeros(input string tag);
      compareBit({tag, " in_ready"}, in_ready, 1'b0);
      compareBit({tag, " busy"}, busy, 1'b0);
      compareBit({tag, " out_valid"}, out_valid, 1'b0);
      compare({tag, " out_min"}, out_min, '0);
      compare({tag, " out_max"}, out_max, '0);
   endtask

   // Feeds word_q; holds in_valid low before word hold_idx, optionally pokes start during CMP_MAX.
   task automatic applyStimulus(input int n, input int hold_idx, input int hold_cycles,
                                input bit poke_start);
      int t;
      start = 1'b1;
      len   = CNT_W'(n);
      tick;
      start = 1'b0;
      len   = 8'hAA;
      for (int i = 0; i < word_q.size(); i++) begin
         if (i == hold_idx) repeat (hold_cycles) tick;
         in_valid = 1'b1;
         in_data  = word_q[i];
         t = 0;
         while (!in_ready && t < 50) begin
            tick;
            t++;
         end
         if (t >= 50) timeoutFail("in_ready wait");
         tick;
         in_valid = 1'b0;
         in_data  = 32'hDEAD_BEEF;
         if (poke_start && i == 1) begin
            tick;
            start = 1'b1;
            len   = 8'd3;
            tick;
            start = 1'b0;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [N-1:0] exp_min,
                              input logic [N-1:0] exp_max, input int done_hold);
      int t = 0;
      while (!out_valid && t < 50) begin
         tick;
         t++;
      end
      if (t >= 50) timeoutFail({tag, " out_valid wait"});
      compare({tag, " min"}, out_min, exp_min);
      compare({tag, " max"}, out_max, exp_max);
      if (done_hold > 0) begin
         repeat (done_hold) tick;
         compareBit({tag, " held valid"}, out_valid, 1'b1);
         compare({tag, " held min"}, out_min, exp_min);
         compare({tag, " held max"}, out_max, exp_max);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      compareBit({tag, " idle after"}, busy, 1'b0);
   endtask

   initial begin
      logic signed [N-1:0] emin, emax, w;

      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (2) tick;
      checkZeros("reset");
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;

      // Single word; start accepted on the first edge after reset release.
      start = 1'b1; len = 8'd1;
      tick;
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'h0000_0005;
      tick;
      in_valid = 1'b0;
      compareBit("len1 valid at 2 cycles", out_valid, 1'b1);
      checkOutput("len1", 32'd5, 32'd5, 0);

      word_q = '{32'd3, 32'hFFFF_FFF9, 32'd12, 32'hFFFF_FFF9};
      applyStimulus(4, -1, 0, 1'b0);
      checkOutput("len4", 32'hFFFF_FFF9, 32'd12, 0);

      word_q = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
      applyStimulus(3, -1, 0, 1'b0);
      checkOutput("extremes", 32'h8000_0000, 32'h7FFF_FFFF, 0);

      word_q = '{32'd10, 32'd20, 32'hFFFF_FFFB};
      applyStimulus(3, 1, 7, 1'b0);
      checkOutput("stall", 32'hFFFF_FFFB, 32'd20, 4);

      start = 1'b1; len = 8'd0;
      tick;
      start = 1'b0;
      tick;
      compareBit("len0 ignored", busy, 1'b0);
      compare("len0 keeps min", out_min, 32'hFFFF_FFFB);

      word_q = '{32'd4, 32'd9, 32'd1};
      applyStimulus(3, -1, 0, 1'b1);
      checkOutput("poke", 32'd1, 32'd9, 0);
      tick;
      compareBit("poke no restart", busy, 1'b0);

      word_q = '{32'd100, 32'd50};
      applyStimulus(5, -1, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1 checkZeros("midreset");
      #2 rst_n = 1'b1;
      word_q = '{32'd1, 32'hFFFF_FFFF};
      applyStimulus(2, -1, 0, 1'b0);
      checkOutput("post reset", 32'hFFFF_FFFF, 32'd1, 0);

      word_q.delete();
      for (int i = 0; i < 8; i++) word_q.push_back($urandom);
      emin = word_q[0];
      emax = word_q[0];
      foreach (word_q[i]) begin
         w = word_q[i];
         if (w < emin) emin = w;
         if (w > emax) emax = w;
      end
      applyStimulus(8, 3, 2, 1'b0);
      checkOutput("random8", emin, emax, 1);

      repeat (3) tick;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
